// File: rtl/insn_queue_if.sv
// Packet type shared by fetch, queue and dispatch, plus the fetch/dispatch-side
// bundle of the instruction queue (clock and reset stay plain ports).
package insn_queue_pkg;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] npc;
      logic        valid;
   } if_id_packet_t;

   localparam if_id_packet_t NOP_PACKET = '{inst: NOP_INST, pc: 32'h0, npc: 32'h0, valid: 1'b0};
endpackage

interface insn_queue_if #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(WIDTH + 1),
   parameter int OW    = $clog2(DEPTH + 1)
);
   logic                                       enable;
   logic                                       squash;
   insn_queue_pkg::if_id_packet_t [WIDTH-1:0]  if_packet_in;
   logic [CW-1:0]                              if_accept_cnt;
   logic [CW-1:0]                              rob_free;
   logic [CW-1:0]                              rs_free;
   logic                                       sq_full;
   insn_queue_pkg::if_id_packet_t [WIDTH-1:0]  dp_packet_out;
   logic [CW-1:0]                              dp_count;
   logic [OW-1:0]                              occupancy;
   logic                                       full;
   logic                                       empty;

   modport master (
      output enable, squash, if_packet_in, rob_free, rs_free, sq_full,
      input  if_accept_cnt, dp_packet_out, dp_count, occupancy, full, empty
   );

   modport slave (
      input  enable, squash, if_packet_in, rob_free, rs_free, sq_full,
      output if_accept_cnt, dp_packet_out, dp_count, occupancy, full, empty
   );
endinterface

// File: rtl/insn_queue.sv
// Circular instruction queue between fetch and dispatch: compacts valid fetch
// lanes on write, releases an in-order prefix limited by back-end resources.
module insn_queue
   import insn_queue_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(WIDTH + 1),
   parameter int OW    = $clog2(DEPTH + 1)
) (
   input logic          clock,
   input logic          reset,
   insn_queue_if.slave  bus
);
   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   if_id_packet_t   slot_q [DEPTH];
   if_id_packet_t   slot_d [DEPTH];
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   rptr_q, rptr_d;

   logic            run_s;
   logic [OW-1:0]   occ_s;
   logic [OW-1:0]   free_s;
   logic [OW-1:0]   in_valid_s;
   logic [OW-1:0]   accept_s;
   logic [OW-1:0]   avail_s;
   logic [OW-1:0]   dp_cnt_s;
   logic [OW-1:0]   rank_s;

   function automatic logic [OW-1:0] min_f(input logic [OW-1:0] a, input logic [OW-1:0] b);
      return (a < b) ? a : b;
   endfunction

   // Occupancy relies on DEPTH being a power of two so PW == OW.
   assign occ_s  = OW'(wptr_q - rptr_q);
   assign free_s = OW'(DEPTH) - occ_s;
   assign run_s  = reset & ~bus.squash & bus.enable;

   always_comb begin
      in_valid_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         in_valid_s = in_valid_s + {{(OW-1){1'b0}}, bus.if_packet_in[i].valid};
      end
      accept_s = run_s ? min_f(in_valid_s, free_s) : '0;
      avail_s  = min_f(min_f(occ_s, OW'(bus.rob_free)), min_f(OW'(bus.rs_free), OW'(WIDTH)));
      dp_cnt_s = (run_s && !bus.sq_full) ? avail_s : '0;
      wptr_d   = wptr_q + PW'(accept_s);
      rptr_d   = rptr_q + PW'(dp_cnt_s);
   end

   // Compaction: the k-th accepted valid lane lands at wptr+k.
   always_comb begin
      slot_d = slot_q;
      rank_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (bus.if_packet_in[i].valid && (rank_s < accept_s)) begin
            slot_d[wptr_q[IW-1:0] + IW'(rank_s)] = bus.if_packet_in[i];
            rank_s = rank_s + OW'(1);
         end else begin
            rank_s = rank_s;
         end
      end
   end

   always_comb begin
      bus.dp_packet_out = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (OW'(i) < dp_cnt_s) begin
            bus.dp_packet_out[i] = slot_q[rptr_q[IW-1:0] + IW'(i)];
         end else begin
            bus.dp_packet_out[i] = NOP_PACKET;
         end
      end
   end

   assign bus.if_accept_cnt = CW'(accept_s);
   assign bus.dp_count      = CW'(dp_cnt_s);
   assign bus.occupancy     = occ_s;
   assign bus.full          = (free_s < OW'(WIDTH));
   assign bus.empty         = (occ_s == '0);

   // Reset and squash both empty the queue and scrub every slot.
   always_ff @(posedge clock) begin
      if (!reset || bus.squash) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            slot_q[k] <= NOP_PACKET;
         end
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         slot_q <= slot_d;
      end
   end
endmodule

// File: tb/tb_insn_queue.sv
// Self-checking bench for insn_queue: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_insn_queue;
   import insn_queue_pkg::*;

   localparam int W = 3;
   localparam int D = 16;

   logic clk;
   logic reset;

   insn_queue_if #(.WIDTH(W), .DEPTH(D)) bus ();

   insn_queue #(.WIDTH(W), .DEPTH(D)) dut (
      .clock (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   if_id_packet_t mq[$];
   bit            known = 1'b0;
   int            exp_acc;
   int            exp_dp;
   int            nchecks = 0;
   int            nerr = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic if_id_packet_t mk(input logic [31:0] pc, input logic v);
      if_id_packet_t p;
      p.inst  = 32'h0050_0093 ^ pc;
      p.pc    = pc;
      p.npc   = pc + 32'd4;
      p.valid = v;
      return p;
   endfunction

   // Lane i carries PC base+4*i; invalid lanes still carry a recognisable PC.
   task automatic set_lanes(input logic [2:0] mask, input logic [31:0] base);
      for (int i = 0; i < W; i++) begin
         bus.if_packet_in[i] = mk(base + 32'(4 * i), mask[i]);
      end
   endtask

   task automatic set_res(input int rob, input int rs);
      bus.rob_free = 2'(rob);
      bus.rs_free  = 2'(rs);
   endtask

   // Reference: expectations from queue contents and the accept/dispatch rules.
   task automatic eval_and_check();
      int v, fr, m;
      if_id_packet_t e;
      #1;
      v = 0;
      for (int i = 0; i < W; i++) v += int'(bus.if_packet_in[i].valid);
      if (!reset || bus.squash || !bus.enable) begin
         exp_acc = 0;
         exp_dp  = 0;
      end else begin
         fr      = D - mq.size();
         exp_acc = (v < fr) ? v : fr;
         m = mq.size();
         if (int'(bus.rob_free) < m) m = int'(bus.rob_free);
         if (int'(bus.rs_free) < m) m = int'(bus.rs_free);
         if (W < m) m = W;
         exp_dp = bus.sq_full ? 0 : m;
      end
      check("if_accept_cnt", 128'(bus.if_accept_cnt), 128'(exp_acc));
      check("dp_count", 128'(bus.dp_count), 128'(exp_dp));
      for (int i = 0; i < W; i++) begin
         e = (i < exp_dp) ? mq[i] : NOP_PACKET;
         check($sformatf("dp_lane%0d", i), 128'(bus.dp_packet_out[i]), 128'(e));
      end
      if (known) begin
         check("occupancy", 128'(bus.occupancy), 128'(mq.size()));
         check("full", 128'(bus.full), 128'((D - mq.size()) < W));
         check("empty", 128'(bus.empty), 128'(mq.size() == 0));
         check("occ_le_depth", 128'(int'(bus.occupancy) <= D), 128'(1));
         check("dp_le_occ", 128'(bus.dp_count <= bus.occupancy), 128'(1));
      end
   endtask

   task automatic tick();
      int n;
      @(posedge clk);
      if (!reset) begin
         mq.delete();
         known = 1'b1;
      end else if (bus.squash) begin
         mq.delete();
      end else begin
         repeat (exp_dp) void'(mq.pop_front());
         n = 0;
         for (int i = 0; i < W; i++) begin
            if (bus.if_packet_in[i].valid && n < exp_acc) begin
               mq.push_back(bus.if_packet_in[i]);
               n++;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic step();
      eval_and_check();
      tick();
   endtask

   int fill_acc [7] = '{3, 3, 3, 3, 3, 1, 0};
   int fill_full[7] = '{0, 0, 0, 0, 0, 1, 1};

   initial begin
      int sent, disp, guard;
      logic [2:0] mask;
      reset = 1'b0;
      bus.enable = 1'b1;
      bus.squash = 1'b0;
      bus.sq_full = 1'b0;
      set_res(0, 0);
      set_lanes(3'b111, 32'h0);

      // Reset for two cycles while fetch presents valid lanes.
      repeat (2) begin
         eval_and_check();
         check("reset_acc", 128'(bus.if_accept_cnt), 128'(0));
         tick();
      end
      reset = 1'b1;

      // Fill with nothing dispatched.
      for (int c = 0; c < 7; c++) begin
         set_lanes(3'b111, 32'(c * 12));
         eval_and_check();
         check("fill_acc", 128'(bus.if_accept_cnt), 128'(fill_acc[c]));
         check("fill_full", 128'(bus.full), 128'(fill_full[c]));
         tick();
      end
      set_lanes(3'b000, 32'h0);
      set_res(3, 3);
      eval_and_check();
      check("fill_occ16", 128'(bus.occupancy), 128'(16));
      tick();
      step();
      set_res(1, 1);
      step();

      // Squash at occupancy 9 with valid input.
      set_lanes(3'b111, 32'h400);
      set_res(3, 3);
      bus.squash = 1'b1;
      eval_and_check();
      check("sq_occ9", 128'(bus.occupancy), 128'(9));
      check("sq_acc", 128'(bus.if_accept_cnt), 128'(0));
      check("sq_dp", 128'(bus.dp_count), 128'(0));
      tick();
      bus.squash = 1'b0;
      set_lanes(3'b000, 32'h0);
      eval_and_check();
      check("sq_empty", 128'(bus.empty), 128'(1));
      check("sq_lane0", 128'(bus.dp_packet_out[0]), 128'(NOP_PACKET));
      tick();

      // Same squash with reset asserted alongside.
      set_res(0, 0);
      for (int c = 0; c < 3; c++) begin
         set_lanes(3'b111, 32'(32'h500 + c * 12));
         step();
      end
      set_res(3, 3);
      bus.squash = 1'b1;
      reset = 1'b0;
      eval_and_check();
      check("sqr_acc", 128'(bus.if_accept_cnt), 128'(0));
      check("sqr_dp", 128'(bus.dp_count), 128'(0));
      tick();
      bus.squash = 1'b0;
      reset = 1'b1;
      set_lanes(3'b000, 32'h0);
      eval_and_check();
      check("sqr_occ", 128'(bus.occupancy), 128'(0));
      check("sqr_empty", 128'(bus.empty), 128'(1));
      tick();

      // Compaction of {valid, invalid, valid}.
      set_res(0, 0);
      set_lanes(3'b101, 32'h100);
      eval_and_check();
      check("cmp_acc", 128'(bus.if_accept_cnt), 128'(2));
      tick();
      set_lanes(3'b000, 32'h0);
      set_res(3, 3);
      eval_and_check();
      check("cmp_dp", 128'(bus.dp_count), 128'(2));
      check("cmp_pc0", 128'(bus.dp_packet_out[0].pc), 128'(32'h100));
      check("cmp_pc1", 128'(bus.dp_packet_out[1].pc), 128'(32'h108));
      check("cmp_lane2", 128'(bus.dp_packet_out[2]), 128'(NOP_PACKET));
      tick();

      // Resource limit and store-queue stall at occupancy 5.
      set_res(0, 0);
      set_lanes(3'b111, 32'h200);
      step();
      set_lanes(3'b011, 32'h300);
      step();
      set_lanes(3'b000, 32'h0);
      set_res(3, 1);
      eval_and_check();
      check("res_occ5", 128'(bus.occupancy), 128'(5));
      check("res_dp", 128'(bus.dp_count), 128'(1));
      tick();
      set_res(3, 3);
      bus.sq_full = 1'b1;
      eval_and_check();
      check("res_occ4", 128'(bus.occupancy), 128'(4));
      check("sqf_dp", 128'(bus.dp_count), 128'(0));
      tick();
      bus.sq_full = 1'b0;
      set_res(0, 0);
      eval_and_check();
      check("sqf_frozen", 128'(bus.occupancy), 128'(4));
      tick();

      // Partial accept near full.
      for (int c = 0; c < 3; c++) begin
         set_lanes(3'b111, 32'(32'h600 + c * 12));
         step();
      end
      set_lanes(3'b011, 32'h700);
      step();
      set_lanes(3'b111, 32'h800);
      set_res(2, 2);
      eval_and_check();
      check("nf_occ15", 128'(bus.occupancy), 128'(15));
      check("nf_acc", 128'(bus.if_accept_cnt), 128'(1));
      check("nf_dp", 128'(bus.dp_count), 128'(2));
      tick();
      set_lanes(3'b000, 32'h0);
      set_res(0, 0);
      eval_and_check();
      check("nf_occ14", 128'(bus.occupancy), 128'(14));
      tick();
      bus.squash = 1'b1;
      step();
      bus.squash = 1'b0;

      // In-order stream of 40 PCs through several wraps.
      sent = 0;
      disp = 0;
      guard = 0;
      while (disp < 40 && guard < 2000) begin
         int k;
         k = 0;
         for (int i = 0; i < W; i++) begin
            if ($urandom_range(0, 3) != 0 && (sent + k) < 40) begin
               bus.if_packet_in[i] = mk(32'((sent + k) * 4), 1'b1);
               k++;
            end else begin
               bus.if_packet_in[i] = mk(32'hDEAD_0000 + 32'(i), 1'b0);
            end
         end
         set_res($urandom_range(0, 3), $urandom_range(0, 3));
         bus.sq_full = ($urandom_range(0, 7) == 0);
         bus.enable  = ($urandom_range(0, 9) != 0);
         eval_and_check();
         for (int i = 0; i < exp_dp; i++) begin
            check("stream_pc", 128'(bus.dp_packet_out[i].pc), 128'(disp * 4));
            disp++;
         end
         sent += exp_acc;
         guard++;
         tick();
      end
      check("stream_count", 128'(disp), 128'(40));
      bus.enable = 1'b1;
      bus.sq_full = 1'b0;

      // Randomized traffic including squash, reset and stalls.
      for (int c = 0; c < 400; c++) begin
         mask = 3'($urandom_range(0, 7));
         set_lanes(mask, $urandom() & 32'hFFFF_FFFC);
         set_res($urandom_range(0, 3), $urandom_range(0, 3));
         bus.sq_full = ($urandom_range(0, 5) == 0);
         bus.enable  = ($urandom_range(0, 7) != 0);
         bus.squash  = ($urandom_range(0, 19) == 0);
         reset       = ($urandom_range(0, 49) != 0);
         step();
      end
      reset = 1'b1;
      bus.squash = 1'b0;

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end
endmodule

// File: doc/insn_queue.md
Name: insn_queue

Overview:
- Parametrised successor to the fetch-side instruction buffer: a circular FIFO between fetch and dispatch, N lanes wide.
- Accepts up to WIDTH fetched instructions per cycle and compacts non-contiguous valid lanes.
- Reports to fetch how many lanes it took, so fetch replays the rest (partial accept).
- Releases up to WIDTH instructions per cycle, in program order, limited by ROB/RS free slots and store-queue state; flushes on squash.

Parameters:
- WIDTH, 3, fetch and dispatch lanes per cycle (1..4).
- DEPTH, 16, queue entries; power of two, DEPTH >= 2*WIDTH.
- CW, $clog2(WIDTH+1), width of per-cycle lane counts.
- OW, $clog2(DEPTH+1), width of occupancy.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; reset==0 at a clock edge clears the block
- enable  in  1  0 = global stall: no state change, if_accept_cnt=0, dp_count=0
- squash  in  1  branch-mispredict flush; synchronous
- if_packet_in  in  [WIDTH] IF_ID_PACKET  fetched lanes; lane 0 is oldest
- if_accept_cnt  out  CW  number of valid input lanes taken this cycle
- rob_free  in  CW  free ROB entries (saturated at WIDTH)
- rs_free  in  CW  free RS entries (saturated at WIDTH)
- sq_full  in  1  store queue full; blocks all dispatch
- dp_packet_out  out  [WIDTH] IF_ID_PACKET  dispatched lanes; lane 0 is oldest
- dp_count  out  CW  number of valid dispatch lanes
- occupancy  out  OW  entries currently held
- full  out  1  (DEPTH - occupancy) < WIDTH
- empty  out  1  occupancy == 0

Behaviour:
- State: slot[DEPTH]; wptr and rptr, each $clog2(DEPTH)+1 bits (index plus wrap bit).
  - occupancy = wptr - rptr, modulo 2*DEPTH.
  - full/empty use the wrap bit; indices wrap at DEPTH with no special case.
- Reset (reset==0 at edge): wptr=rptr=0; every slot set to inst=`NOP, PC=0, NPC=0, valid=0.
  - While reset==0: if_accept_cnt=0, dp_count=0, all dp lanes invalid.
  - After release: occupancy=0, empty=1, full=0.
- Invalid dp lane: inst=`NOP, PC=0, NPC=0, valid=0.
  - Valid dp lanes are always the contiguous prefix 0..dp_count-1.
- Enqueue (combinational count, registered write):
  - v = number of valid input lanes; free = DEPTH - occupancy, using registered occupancy only. Dequeues in the same cycle do not create space.
  - if_accept_cnt = min(v, free).
  - The first if_accept_cnt valid lanes, in lane order and skipping invalid lanes, are written to slot[wptr], slot[wptr+1], ...
  - wptr advances by if_accept_cnt at the edge.
  - Lanes not accepted are dropped; fetch re-presents them.
- Dequeue:
  - dp_count = 0 if sq_full, enable==0 or squash==1.
  - Otherwise dp_count = min(occupancy, rob_free, rs_free, WIDTH).
  - dp_packet_out[i] = slot[rptr+i] for i < dp_count.
  - rptr advances by dp_count at the edge. No bypass: an instruction written at edge N is dispatchable from cycle N+1.
- Simultaneous enqueue and dequeue: both pointers update at the same edge. Occupancy_next = occupancy + if_accept_cnt - dp_count.
- Squash (squash==1, reset==1):
  - Same cycle: if_accept_cnt=0 and dp_count=0.
  - At the edge: wptr=rptr=0 and all slots invalidated.
  - Squash has priority over enable.
- Reset has priority over squash.
- enable==0 with squash==1: the squash still takes effect.
- Full case: occupancy == DEPTH gives if_accept_cnt=0. Dispatch continues normally.
- Empty case: dp_count=0 regardless of rob_free and rs_free.
- Occupancy can never exceed DEPTH. Verification asserts this, and also asserts dp_count <= occupancy.

Test Plan:
- Reset then fill: reset=0 for 2 cycles, release; WIDTH=3, 3 valid lanes per cycle, rob_free=rs_free=0 -> if_accept_cnt=3,3,3,3,3,1,0. Occupancy reaches 16, full=1 from occupancy 14.
- Compaction: lanes {valid,invalid,valid} with PCs 0x100,-,0x108 into an empty queue -> if_accept_cnt=2. Next cycle with rob_free=rs_free=3: dp_count=2, lane0 PC=0x100, lane1 PC=0x108, lane2 NOP.
- Resource limit: occupancy 5, rob_free=3, rs_free=1 -> dp_count=1, occupancy 4 next cycle. Raise sq_full=1 with rob_free=rs_free=3 -> dp_count=0 and rptr frozen.
- Wrap-around: stream 40 sequential PCs (0x0, 0x4, ...) with random rob_free/rs_free -> dispatched PC sequence is exactly in order with no loss or duplication, through at least two wraps.
- Partial accept at near-full: occupancy 15, 3 valid lanes in, dp_count=2 -> if_accept_cnt=1; occupancy next = 15 + 1 - 2 = 14.
- Squash mid-stream: occupancy 9 with valid input, squash=1 -> if_accept_cnt=0 and dp_count=0 that cycle. Next cycle occupancy=0, empty=1, all dp lanes NOP. Same stimulus with reset=0 asserted alongside gives an identical result.
